// File: rtl/bg_effect_if.sv
// bg_effect_if: game-logic controls into the effect sequencer and the
// frame-committed hue/brightness controls out to the background colour path.
interface bg_effect_if;
    logic [12:0] pixel_index;
    logic        cycle_en;
    logic        flash_req;
    logic        pause;
    logic [8:0]  hue_offset;
    logic [7:0]  value_scale;
    logic        effect_busy;
    logic [1:0]  state;
    modport master (output pixel_index, cycle_en, flash_req, pause,
                    input  hue_offset, value_scale, effect_busy, state);
    modport slave  (input  pixel_index, cycle_en, flash_req, pause,
                    output hue_offset, value_scale, effect_busy, state);
endinterface

// File: rtl/bg_effect_sequencer.sv
// bg_effect_sequencer: hue cycling plus hit-flash/fade brightness sequencing,
// with both outputs committed only on OLED frame edges to avoid tearing.
module bg_effect_sequencer #(
    parameter int TICK_DIV     = 10_000_000,
    parameter int HUE_STEP     = 1,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_LOW    = 64,
    parameter int FADE_STEP    = 32
) (
    input  logic clk,
    input  logic rst_n,
    bg_effect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CYCLE, FLASH, FADE} state_t;
    localparam int TW = $clog2(TICK_DIV);

    state_t        r_state, w_state_nx;
    logic [7:0]    r_val, w_val_nx, w_fade_val;
    logic [8:0]    r_cnt, w_cnt_nx, w_cnt_inc, w_fade_sum;
    logic [8:0]    r_pend, r_hue, w_pend_nx;
    logic [9:0]    w_pend_sum;
    logic [TW-1:0] r_tick;
    logic [12:0]   r_prev;
    logic          r_busy, w_edge, w_tc;

    assign w_edge     = (bus.pixel_index == 13'd0) && (r_prev != 13'd0);
    assign w_tc       = r_tick == TW'(TICK_DIV - 1);
    assign w_pend_sum = {1'b0, r_pend} + 10'(HUE_STEP);
    assign w_pend_nx  = w_pend_sum >= 10'd360 ? 9'(w_pend_sum - 10'd360) : w_pend_sum[8:0];
    assign w_cnt_inc  = r_cnt + 9'd1;
    assign w_fade_sum = {1'b0, r_val} + 9'(FADE_STEP);
    assign w_fade_val = w_fade_sum >= 9'd255 ? 8'd255 : w_fade_sum[7:0];

    always_comb begin
        w_state_nx = r_state;
        w_val_nx   = r_val;
        w_cnt_nx   = r_cnt;
        if (!bus.pause) begin
            // a hit always restarts the flash, even mid-effect
            if (bus.flash_req) begin
                w_state_nx = FLASH;
                w_cnt_nx   = '0;
            end else begin
                case (r_state)
                    IDLE:  w_state_nx = bus.cycle_en ? CYCLE : IDLE;
                    CYCLE: w_state_nx = bus.cycle_en ? CYCLE : IDLE;
                    FLASH: if (w_edge) begin
                        w_cnt_nx = w_cnt_inc;
                        if (w_cnt_inc > 9'(FLASH_FRAMES)) begin
                            w_state_nx = FADE;
                            w_val_nx   = 8'(FLASH_LOW);
                        end else begin
                            w_val_nx = w_cnt_inc[0] ? 8'(FLASH_LOW) : 8'd255;
                        end
                    end
                    FADE: if (w_edge) begin
                        w_val_nx = w_fade_val;
                        if (w_fade_val == 8'd255) w_state_nx = bus.cycle_en ? CYCLE : IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_val   <= 8'd255;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_val   <= w_val_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= (w_state_nx == FLASH) || (w_state_nx == FADE);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_prev <= '0;
            r_tick <= '0;
            r_pend <= '0;
            r_hue  <= '0;
        end else begin
            r_prev <= bus.pixel_index;
            if (!bus.pause) begin
                if (w_edge) r_hue <= r_pend;
                r_tick <= (!bus.cycle_en || w_tc) ? '0 : r_tick + TW'(1);
                if (bus.cycle_en && w_tc) r_pend <= w_pend_nx;
            end
        end

    assign bus.hue_offset  = r_hue;
    assign bus.value_scale = r_val;
    assign bus.effect_busy = r_busy;
    assign bus.state       = r_state;
endmodule
